// File: rtl/input_dev_pkg.sv
// Shared constants for the input_dev buffered input peripheral:
// register map, STATUS/CTRL bit positions and the default buffer depth.
package input_dev_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int DATA_W        = 32;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_CTRL   = 2'b10;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_CNT_LSB = 2;
  localparam int STAT_CNT_MSB = 6;
  localparam int STAT_OVR_LSB = 24;
  localparam int STAT_OVR_MSB = 31;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

endpackage

// File: rtl/input_dev_fifo.sv
// Word buffer for input_dev: circular storage with read/write pointers,
// occupancy count and a synchronous flush that overrides any push.
module in_fifo
  import input_dev_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rptr];

  // Storage needs no reset: a word is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/input_dev.sv
// Buffered external-input peripheral: CPU register decode (DATA/STATUS/CTRL),
// producer handshake, saturating overrun counter and level interrupt.
module input_dev
  import input_dev_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [3:2]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        ext_valid,
  input  logic [31:0] ext_data,
  output logic        ext_ready,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          ctrl_enable;
  logic          irq_enable;
  logic [7:0]    overrun_cnt;
  logic [31:0]   rdata;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          ctrl_wr;
  logic          flush;
  logic [4:0]    count5;
  logic [31:0]   status;
  logic          unused_din;

  assign unused_din = ^din[31:3];

  assign ext_ready = !full && ctrl_enable;
  assign push      = ext_valid && ext_ready;
  assign pop       = en && !we && (addr == ADDR_DATA) && !empty;
  assign ctrl_wr   = en && we && (addr == ADDR_CTRL);
  assign flush     = ctrl_wr && din[CTRL_FLUSH];
  assign irq       = irq_enable && !empty;
  assign count5    = 5'(count);

  in_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (ext_data),
    .rdata (rdata),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_enable <= 1'b1;
      irq_enable  <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_enable <= din[CTRL_ENABLE];
      irq_enable  <= din[CTRL_IRQ_EN];
    end
  end

  // A producer offering while enabled but full loses its word; count it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (flush) begin
      overrun_cnt <= '0;
    end else if (ext_valid && ctrl_enable && full && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  always_comb begin
    status                            = '0;
    status[STAT_EMPTY]                = empty;
    status[STAT_FULL]                 = full;
    status[STAT_CNT_MSB:STAT_CNT_LSB] = count5;
    status[STAT_OVR_MSB:STAT_OVR_LSB] = overrun_cnt;
  end

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_DATA:   dout = empty ? 32'd0 : rdata;
      ADDR_STATUS: dout = status;
      ADDR_CTRL:   dout = {30'd0, irq_enable, ctrl_enable};
      default:     dout = '0;
    endcase
  end

endmodule

// File: tb/tb_input_dev.sv
// Directed self-checking bench for input_dev (DEPTH = 4).
module tb_input_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        we;
  logic [3:2]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ext_valid;
  logic [31:0] ext_data;
  logic        ext_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  input_dev dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .ext_valid (ext_valid),
    .ext_data  (ext_data),
    .ext_ready (ext_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    en = 1'b1; we = 1'b0; addr = a;
    #1 d = dout;
    tick();
    en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data);
    en = 1'b1; we = 1'b1; addr = a; din = data;
    tick();
    en = 1'b0; we = 1'b0; din = '0;
  endtask

  task automatic push_word(input logic [31:0] data);
    ext_valid = 1'b1; ext_data = data;
    tick();
    ext_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ext_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ext_ready); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL reset_status: got %h expected 00000001", d); end
    rd(2'b10, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000001", d); end
  endtask

  task automatic test_fifo_order;
    logic [31:0] d;
    logic [31:0] exp_q [3] = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) push_word(exp_q[i]);
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_000C) begin errors++; $display("FAIL order_status3: got %h expected 0000000c", d); end
    for (int i = 0; i < 3; i++) begin
      rd(2'b00, d);
      checks++;
      if (d !== exp_q[i]) begin errors++; $display("FAIL order_data%0d: got %h expected %h", i, d, exp_q[i]); end
    end
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL order_status_empty: got %h expected 00000001", d); end
    rd(2'b00, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL empty_data_read: got %h expected 00000000", d); end
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL empty_read_nochange: got %h expected 00000001", d); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    ext_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext_data = 32'hA0 + 32'(i);
      tick();
    end
    checks++;
    if (ext_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", ext_ready); end
    en = 1'b1; we = 1'b0; addr = 2'b01;
    #1;
    checks++;
    if (dout !== 32'h0000_0012) begin errors++; $display("FAIL full_status: got %h expected 00000012", dout); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ext_data = 32'hE0 + 32'(i);
      tick();
    end
    ext_valid = 1'b0;
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0300_0012) begin errors++; $display("FAIL overrun_status: got %h expected 03000012", d); end
    rd(2'b00, d);
    checks++;
    if (d !== 32'hA0) begin errors++; $display("FAIL overrun_dropped: got %h expected 000000a0", d); end
    wr(2'b10, 32'h5);
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL flush_status: got %h expected 00000001", d); end
    rd(2'b10, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL flush_ctrl: got %h expected 00000001", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    push_word(32'h55);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
    wr(2'b10, 32'h3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
    rd(2'b00, d);
    checks++;
    if (d !== 32'h55) begin errors++; $display("FAIL irq_data: got %h expected 00000055", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    wr(2'b10, 32'h1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    push_word(32'h01);
    push_word(32'h02);
    ext_valid = 1'b1; ext_data = 32'hAA;
    rd(2'b00, d);
    ext_valid = 1'b0;
    checks++;
    if (d !== 32'h01) begin errors++; $display("FAIL simul_head: got %h expected 00000001", d); end
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_0008) begin errors++; $display("FAIL simul_count: got %h expected 00000008", d); end
    rd(2'b00, d);
    checks++;
    if (d !== 32'h02) begin errors++; $display("FAIL simul_second: got %h expected 00000002", d); end
    rd(2'b00, d);
    checks++;
    if (d !== 32'hAA) begin errors++; $display("FAIL simul_third: got %h expected 000000aa", d); end
    // Full: a pop must not open a same-cycle push, and the offer counts as an overrun.
    for (int i = 0; i < 4; i++) push_word(32'hB0 + 32'(i));
    ext_valid = 1'b1; ext_data = 32'hCC;
    rd(2'b00, d);
    ext_valid = 1'b0;
    checks++;
    if (d !== 32'hB0) begin errors++; $display("FAIL fullpop_head: got %h expected 000000b0", d); end
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0100_000C) begin errors++; $display("FAIL fullpop_status: got %h expected 0100000c", d); end
    // Flush on the same edge as a push: flush wins.
    ext_valid = 1'b1; ext_data = 32'hDD;
    wr(2'b10, 32'h5);
    ext_valid = 1'b0;
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL flush_vs_push: got %h expected 00000001", d); end
  endtask

  task automatic test_disable_and_reserved;
    logic [31:0] d;
    wr(2'b10, 32'h0);
    checks++;
    if (ext_ready !== 1'b0) begin errors++; $display("FAIL disabled_ready: got %b expected 0", ext_ready); end
    push_word(32'h77);
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL disabled_status: got %h expected 00000001", d); end
    wr(2'b10, 32'h1);
    push_word(32'h99);
    wr(2'b11, 32'hFFFF_FFFF);
    wr(2'b01, 32'hFFFF_FFFF);
    wr(2'b00, 32'hFFFF_FFFF);
    rd(2'b11, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected 00000000", d); end
    rd(2'b10, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL ignored_writes_ctrl: got %h expected 00000001", d); end
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL ignored_writes_status: got %h expected 00000004", d); end
    rd(2'b00, d);
    checks++;
    if (d !== 32'h99) begin errors++; $display("FAIL ignored_writes_data: got %h expected 00000099", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    wr(2'b10, 32'h3);
    for (int i = 0; i < 3; i++) push_word(32'hC0 + 32'(i));
    ext_valid = 1'b1; ext_data = 32'hEE;
    rst = 1'b1;
    tick(); tick();
    ext_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b expected 0", irq); end
    rd(2'b01, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL midrst_status: got %h expected 00000001", d); end
    rd(2'b00, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 00000000", d); end
    rd(2'b10, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL midrst_ctrl: got %h expected 00000001", d); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = 2'b00; din = '0;
    ext_valid = 1'b0; ext_data = '0;
    test_reset();
    test_fifo_order();
    test_overrun();
    test_irq();
    test_back_to_back();
    test_disable_and_reserved();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
